divider_unit: RTL and testbench

DIVIDER_UNIT -- requirements
Module: divider_unit

---
 rtl/divider_unit.sv | 147 ++++++++++++++
 tb/tb_divider_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// 32-bit iterative divider: restoring radix-2, one quotient bit per cycle, with
// sign fix-up and single-cycle handling of divide-by-zero and signed overflow.
module divider_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] div_rdata1_i,
  input  logic [31:0] div_rdata2_i,
  input  logic        div_enable_i,
  input  logic [3:0]  div_op_i,
  output logic [31:0] div_result_o,
  output logic        div_ready_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] rq_q, rq_d;
  logic [31:0] divisor_q, divisor_d;
  logic        sel_rem_q, sel_rem_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;
  logic        ready_q, ready_d;

  // Operand decode for the capture cycle; op is one-hot {div, divu, rem, remu}.
  logic        op_signed;
  logic        op_quot;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        overflow;

  assign op_signed = div_op_i[3] | div_op_i[1];
  assign op_quot   = div_op_i[3] | div_op_i[2];
  assign abs_a     = (op_signed && div_rdata1_i[31]) ? (32'd0 - div_rdata1_i) : div_rdata1_i;
  assign abs_b     = (op_signed && div_rdata2_i[31]) ? (32'd0 - div_rdata2_i) : div_rdata2_i;
  assign overflow  = op_signed && (div_rdata1_i == 32'h8000_0000) && (div_rdata2_i == 32'hFFFF_FFFF);

  // One restoring step: shift the next dividend bit into the partial remainder
  // and keep the difference only when it did not go negative.
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic [63:0] rq_step;

  assign rem_shift = {rq_q[63:32], rq_q[31]};
  assign diff      = rem_shift - {1'b0, divisor_q};
  assign rq_step   = diff[32] ? {rem_shift[31:0], rq_q[30:0], 1'b0}
                              : {diff[31:0],      rq_q[30:0], 1'b1};

  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] final_val;

  assign quot_fixed = neg_quot_q ? (32'd0 - rq_q[31:0])  : rq_q[31:0];
  assign rem_fixed  = neg_rem_q  ? (32'd0 - rq_q[63:32]) : rq_q[63:32];
  assign final_val  = sel_rem_q ? rem_fixed : quot_fixed;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rq_d       = rq_q;
    divisor_d  = divisor_q;
    sel_rem_d  = sel_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_enable_i) begin
          sel_rem_d  = div_op_i[1] | div_op_i[0];
          neg_quot_d = div_op_i[3] & (div_rdata1_i[31] ^ div_rdata2_i[31]);
          neg_rem_d  = div_op_i[1] & div_rdata1_i[31];
          if (div_rdata2_i == 32'd0) begin
            result_d = op_quot ? 32'hFFFF_FFFF : div_rdata1_i;
            ready_d  = 1'b1;
            state_d  = DONE;
          end else if (overflow) begin
            result_d = div_op_i[3] ? 32'h8000_0000 : 32'h0000_0000;
            ready_d  = 1'b1;
            state_d  = DONE;
          end else begin
            rq_d      = {32'd0, abs_a};
            divisor_d = abs_b;
            cnt_d     = 5'd31;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        if (!div_enable_i) begin
          state_d = IDLE;
        end else begin
          rq_d = rq_step;
          if (cnt_q == 5'd0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      FIX: begin
        if (!div_enable_i) begin
          state_d = IDLE;
        end else begin
          result_d = final_val;
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      rq_q       <= 64'd0;
      divisor_q  <= 32'd0;
      sel_rem_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= 32'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rq_q       <= rq_d;
      divisor_q  <= divisor_d;
      sel_rem_q  <= sel_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign div_result_o = result_q;
  assign div_ready_o  = ready_q;

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: latency, results, special cases, abort,
// back-to-back, operand stability and asynchronous reset.
module tb_divider_unit;

  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REM  = 4'b0010;
  localparam logic [3:0] OP_REMU = 4'b0001;

  logic        clk;
  logic        rst;
  logic [31:0] div_rdata1_i;
  logic [31:0] div_rdata2_i;
  logic        div_enable_i;
  logic [3:0]  div_op_i;
  logic [31:0] div_result_o;
  logic        div_ready_o;

  int n_checks;
  int n_errors;

  divider_unit dut (
    .clk          (clk),
    .rst          (rst),
    .div_rdata1_i (div_rdata1_i),
    .div_rdata2_i (div_rdata2_i),
    .div_enable_i (div_enable_i),
    .div_op_i     (div_op_i),
    .div_result_o (div_result_o),
    .div_ready_o  (div_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    div_op_i     = op;
    div_rdata1_i = a;
    div_rdata2_i = b;
    div_enable_i = 1'b1;
  endtask

  // Counts negedges until ready is seen; lat=1 means ready in the cycle after the call.
  task automatic wait_ready(input int max, output int lat, output logic seen);
    lat  = 0;
    seen = 1'b0;
    while (lat < max && !seen) begin
      @(negedge clk);
      lat++;
      if (div_ready_o) seen = 1'b1;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int   lat;
    logic seen;
    start(op, a, b);
    wait_ready(60, lat, seen);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, div_result_o, exp_res);
    div_enable_i = 1'b0;
    @(negedge clk);
    check({tag, "_oneshot"}, {31'd0, div_ready_o}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    int   early_ready;
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b0;
    div_enable_i = 1'b0;
    div_op_i     = 4'b0000;
    div_rdata1_i = 32'd0;
    div_rdata2_i = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_ready", {31'd0, div_ready_o}, 32'd0);
    check("reset_result", div_result_o, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run("div_100_7",    OP_DIV,  32'd100,       32'd7, 34, 32'h0000_000E);
    run("rem_m100_7",   OP_REM,  32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFFE);
    run("div_m100_7",   OP_DIV,  32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFF2);
    run("divu_5_0",     OP_DIVU, 32'd5,         32'd0, 1,  32'hFFFF_FFFF);
    run("remu_5_0",     OP_REMU, 32'd5,         32'd0, 1,  32'h0000_0005);
    run("div_ovf",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run("rem_ovf",      OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);
    run("div_min_2",    OP_DIV,  32'h8000_0000, 32'd2, 34, 32'hC000_0000);
    run("remu_max_16",  OP_REMU, 32'hFFFF_FFFF, 32'd16, 34, 32'h0000_000F);

    // Abort: divu 0xFFFFFFFF/2 from cycle t, enable low at t+10 and t+11.
    start(OP_DIVU, 32'hFFFF_FFFF, 32'd2);
    early_ready = 0;
    repeat (10) begin
      @(negedge clk);
      if (div_ready_o) early_ready++;
    end
    div_enable_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (div_ready_o) early_ready++;
    end
    check("abort_noready", early_ready, 0);
    check("abort_result_kept", div_result_o, 32'h0000_000F);
    run("divu_9_4_after_abort", OP_DIVU, 32'd9, 32'd4, 34, 32'h0000_0002);

    // Operands change mid-operation; captured values must be used.
    start(OP_REMU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    div_rdata1_i = 32'd3;
    div_rdata2_i = 32'd1000;
    div_op_i     = OP_DIVU;
    wait_ready(60, lat, seen);
    check("opchg_lat", lat + 5, 34);
    check("opchg_res", div_result_o, 32'h0000_0002);

    // Back-to-back: new operands presented in the DONE cycle, enable held.
    start(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_ready(60, lat, seen);
    check("b2b_lat", lat, 35);
    check("b2b_res", div_result_o, 32'hFFFF_FFFD);
    div_enable_i = 1'b0;
    @(negedge clk);
    check("b2b_oneshot", {31'd0, div_ready_o}, 32'd0);

    // Reset at t+20 of an operation.
    start(OP_DIV, 32'd1000, 32'd3);
    repeat (20) @(negedge clk);
    rst          = 1'b0;
    div_enable_i = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, div_ready_o}, 32'd0);
    check("rst_mid_result", div_result_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_ready(40, lat, seen);
    check("rst_no_ready_after", {31'd0, seen}, 32'd0);
    run("div_1000_3_fresh", OP_DIV, 32'd1000, 32'd3, 34, 32'd333);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
